scan_mux: RTL and testbench

Parametrised, registered N-channel, W-bit multiplexer with a valid/ready output stage and two modes. In direct mode it forwards the channel picked by `sel` on request. In scan mode it walks every channel 0..N-1 in order, with a programmable idle gap between samples. It sits between a bank of parallel sample sources and a single serial consumer, and replaces the fixed 16:1 combinational selector wherever timing, back-pressure or automatic channel sweeping is required.

---
 rtl/scan_mux.sv | 153 +++++++++++++++
 tb/tb_scan_mux.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_mux.sv
// Registered N-channel multiplexer with valid/ready output: forwards a selected
// channel on request (direct mode) or sweeps all channels with an idle gap (scan mode).
`default_nettype none

module scan_mux #(
    parameter int W  = 8,
    parameter int N  = 16,
    parameter int DW = 8,
    localparam int SW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N*W-1:0]   in_data,
    input  logic             mode,
    input  logic [SW-1:0]    sel,
    input  logic             sel_valid,
    input  logic             start,
    input  logic [DW-1:0]    dwell,
    input  logic             abort,
    output logic [W-1:0]     out_data,
    output logic [SW-1:0]    out_ch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_GAP} state_t;

    state_t          state, state_d;
    logic [W-1:0]    data_d;
    logic [SW-1:0]   ch_d;
    logic            valid_d, busy_d, done_d;
    logic [SW-1:0]   chan, chan_d;
    logic [DW-1:0]   gap_cnt, gap_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic            slot_free, xfer;
    logic [SW-1:0]   chan_next;

    // Out-of-range indices select zero rather than wrapping or reading past the bus.
    function automatic logic [W-1:0] pick(input logic [N*W-1:0] d, input logic [SW-1:0] idx);
        logic [W-1:0] r;
        r = '0;
        for (int c = 0; c < N; c++) begin
            if (idx == SW'(c)) r = d[c*W +: W];
        end
        return r;
    endfunction

    assign slot_free = !out_valid || out_ready;
    assign xfer      = out_valid && out_ready;
    assign chan_next = chan + SW'(1);

    always_comb begin
        state_d = state;
        data_d  = out_data;
        ch_d    = out_ch;
        valid_d = out_valid;
        done_d  = 1'b0;
        chan_d  = chan;
        gap_d   = gap_cnt;
        dwell_d = dwell_q;
        case (state)
            ST_IDLE: begin
                if (!mode) begin
                    if (sel_valid && slot_free) begin
                        data_d  = pick(in_data, sel);
                        ch_d    = sel;
                        valid_d = 1'b1;
                    end else if (out_ready) begin
                        valid_d = 1'b0;
                    end
                end else begin
                    // A start coinciding with the done pulse waits for the next cycle.
                    if (start && slot_free && !done) begin
                        data_d  = pick(in_data, '0);
                        ch_d    = '0;
                        chan_d  = '0;
                        valid_d = 1'b1;
                        dwell_d = dwell;
                        state_d = ST_WAIT;
                    end else if (out_ready) begin
                        valid_d = 1'b0;
                    end
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else if (xfer) begin
                    if (chan == SW'(N - 1)) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (dwell_q == '0) begin
                        data_d  = pick(in_data, chan_next);
                        ch_d    = chan_next;
                        chan_d  = chan_next;
                    end else begin
                        valid_d = 1'b0;
                        gap_d   = dwell_q;
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (abort) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_cnt - DW'(1);
                    if (gap_cnt == DW'(1)) begin
                        data_d  = pick(in_data, chan_next);
                        ch_d    = chan_next;
                        chan_d  = chan_next;
                        valid_d = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            chan      <= '0;
            gap_cnt   <= '0;
            dwell_q   <= '0;
        end else begin
            state     <= state_d;
            out_data  <= data_d;
            out_ch    <= ch_d;
            out_valid <= valid_d;
            busy      <= busy_d;
            done      <= done_d;
            chan      <= chan_d;
            gap_cnt   <= gap_d;
            dwell_q   <= dwell_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_scan_mux.sv
// Self-checking bench for scan_mux: a 16-channel instance exercised in direct and
// scan modes against a scoreboard, plus a 12-channel instance for out-of-range selects.
`timescale 1ns/1ps

module tb_scan_mux;
    localparam int W = 8, N = 16, DW = 8, SW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N*W-1:0] in_data;
    logic mode = 1'b0, sel_valid = 1'b0, start = 1'b0, abort = 1'b0, out_ready = 1'b0;
    logic [SW-1:0] sel = '0;
    logic [DW-1:0] dwell = '0;
    logic [W-1:0] out_data;
    logic [SW-1:0] out_ch;
    logic out_valid, busy, done;

    logic [12*W-1:0] in_data12;
    logic [3:0] sel12 = '0;
    logic sel_valid12 = 1'b0;
    logic ready12 = 1'b1;
    logic [W-1:0] out_data12;
    logic [3:0] out_ch12;
    logic out_valid12, busy12, done12;

    int tests = 0;
    int fails = 0;
    logic [11:0] exp_q[$];
    logic [11:0] exp_e;

    scan_mux #(.W(W), .N(N), .DW(DW)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .mode(mode), .sel(sel),
        .sel_valid(sel_valid), .start(start), .dwell(dwell), .abort(abort),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    scan_mux #(.W(W), .N(12), .DW(DW)) u_dut12 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data12), .mode(1'b0), .sel(sel12),
        .sel_valid(sel_valid12), .start(1'b0), .dwell(8'd0), .abort(1'b0),
        .out_data(out_data12), .out_ch(out_ch12), .out_valid(out_valid12),
        .out_ready(ready12), .busy(busy12), .done(done12)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int c);
        exp_q.push_back({4'(c), 8'(c + 'h10)});
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL reset_out_data got %0h want 0", out_data); end
        tests++; if (out_ch !== 4'h0) begin fails++; $display("FAIL reset_out_ch got %0h want 0", out_ch); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        tests++; if ({busy, done} !== 2'b00) begin fails++; $display("FAIL reset_busy_done got %b want 00", {busy, done}); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_direct();
        mode = 1'b0; sel = 4'd5; sel_valid = 1'b1; out_ready = 1'b1;
        push_exp(5);
        step();
        sel_valid = 1'b0;
        @(negedge clk);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL direct_valid got %0b want 1", out_valid); end
        tests++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL direct_underflow got empty want entry"); end
        else begin
            exp_e = exp_q.pop_front();
            if ({out_ch, out_data} !== exp_e) begin fails++; $display("FAIL direct_data got %h want %h", {out_ch, out_data}, exp_e); end
        end
        step();
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL direct_valid_drop got %0b want 0", out_valid); end
        step();
    endtask

    task automatic test_back_to_back();
        mode = 1'b0; sel = 4'd3; sel_valid = 1'b1; out_ready = 1'b0;
        push_exp(3);
        step();
        sel = 4'd9;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if ({out_valid, out_ch, out_data} !== {1'b1, 4'd3, 8'h13}) begin
                fails++; $display("FAIL bp_hold cycle %0d got %b/%0d/%h want 1/3/13", i, out_valid, out_ch, out_data);
            end
            step();
        end
        out_ready = 1'b1;
        push_exp(9);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests++;
            if (!(out_valid && out_ready)) begin fails++; $display("FAIL bp_xfer %0d got valid %0b want 1", i, out_valid); end
            else if (exp_q.size() == 0) begin fails++; $display("FAIL bp_underflow got empty want entry"); end
            else begin
                exp_e = exp_q.pop_front();
                if ({out_ch, out_data} !== exp_e) begin fails++; $display("FAIL bp_data got %h want %h", {out_ch, out_data}, exp_e); end
            end
            step();
            sel_valid = 1'b0;
        end
        @(negedge clk);
        tests++; if (out_valid !== 1'b0 || exp_q.size() != 0) begin fails++; $display("FAIL bp_end got valid %0b q %0d want 0 0", out_valid, exp_q.size()); end
        step();
    endtask

    task automatic test_scan_dwell0();
        int vcnt, first_v, last_v, done_at, dcnt;
        logic busy_after;
        vcnt = 0; first_v = 0; last_v = 0; done_at = 0; dcnt = 0; busy_after = 1'b1;
        mode = 1'b1; dwell = 8'd0; out_ready = 1'b1; start = 1'b1;
        for (int c = 0; c < N; c++) push_exp(c);
        step();
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (out_valid) begin
                vcnt++; if (first_v == 0) first_v = k; last_v = k;
                tests++;
                if (exp_q.size() == 0) begin fails++; $display("FAIL scan0_underflow got empty want entry"); end
                else begin
                    exp_e = exp_q.pop_front();
                    if ({out_ch, out_data} !== exp_e) begin fails++; $display("FAIL scan0_data got %h want %h", {out_ch, out_data}, exp_e); end
                end
            end
            if (done) begin dcnt++; if (done_at == 0) begin done_at = k; busy_after = busy; end end
            step();
        end
        tests++; if (vcnt != 16 || first_v != 1 || last_v != 16) begin fails++; $display("FAIL scan0_span got %0d cycles %0d..%0d want 16 1..16", vcnt, first_v, last_v); end
        tests++; if (done_at != 17 || dcnt != 1) begin fails++; $display("FAIL scan0_done got cycle %0d count %0d want 17 1", done_at, dcnt); end
        tests++; if (busy_after !== 1'b0) begin fails++; $display("FAIL scan0_busy got %0b want 0", busy_after); end
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL scan0_left got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_scan_dwell3();
        int vcnt, last_v, done_at, dcnt, bad_gaps, xcnt;
        vcnt = 0; last_v = 0; done_at = 0; dcnt = 0; bad_gaps = 0;
        mode = 1'b1; dwell = 8'd3; out_ready = 1'b1; start = 1'b1;
        for (int c = 0; c < N; c++) push_exp(c);
        step();
        start = 1'b0; dwell = 8'd0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (out_valid) begin
                vcnt++;
                if (last_v != 0 && (k - last_v - 1) != 3) bad_gaps++;
                last_v = k;
                tests++;
                if (exp_q.size() == 0) begin fails++; $display("FAIL scan3_underflow got empty want entry"); end
                else begin
                    exp_e = exp_q.pop_front();
                    if ({out_ch, out_data} !== exp_e) begin fails++; $display("FAIL scan3_data got %h want %h", {out_ch, out_data}, exp_e); end
                end
            end
            if (done) begin dcnt++; if (done_at == 0) done_at = k; end
            step();
        end
        tests++; if (vcnt != 16 || bad_gaps != 0) begin fails++; $display("FAIL scan3_gaps got %0d samples %0d bad gaps want 16 0", vcnt, bad_gaps); end
        tests++; if (done_at != 62 || dcnt != 1) begin fails++; $display("FAIL scan3_done got cycle %0d count %0d want 62 1", done_at, dcnt); end

        xcnt = 0; dcnt = 0;
        dwell = 8'd3; out_ready = 1'b1; start = 1'b1;
        for (int c = 0; c < N; c++) push_exp(c);
        step();
        start = 1'b0;
        for (int k = 0; k < 300 && dcnt == 0; k++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                xcnt++;
                tests++;
                if (exp_q.size() == 0) begin fails++; $display("FAIL scan3t_underflow got empty want entry"); end
                else begin
                    exp_e = exp_q.pop_front();
                    if ({out_ch, out_data} !== exp_e) begin fails++; $display("FAIL scan3t_data got %h want %h", {out_ch, out_data}, exp_e); end
                end
            end
            if (done) dcnt++;
            step();
            out_ready = ~out_ready;
        end
        out_ready = 1'b1;
        tests++; if (xcnt != 16 || dcnt != 1 || exp_q.size() != 0) begin fails++; $display("FAIL scan3t_count got %0d xfers %0d done %0d left want 16 1 0", xcnt, dcnt, exp_q.size()); end
        repeat (2) step();
    endtask

    task automatic test_abort();
        int xcnt, dcnt;
        logic found;
        xcnt = 0; dcnt = 0; found = 1'b0;
        mode = 1'b1; dwell = 8'd3; out_ready = 1'b1; start = 1'b1;
        for (int c = 0; c < N; c++) push_exp(c);
        step();
        start = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                xcnt++;
                tests++;
                exp_e = exp_q.pop_front();
                if ({out_ch, out_data} !== exp_e) begin fails++; $display("FAIL abort_data got %h want %h", {out_ch, out_data}, exp_e); end
            end
            if (busy && !out_valid && out_ch == 4'd6) found = 1'b1;
            step();
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        tests++; if (!found || xcnt != 7) begin fails++; $display("FAIL abort_reach got found %0b xfers %0d want 1 7", found, xcnt); end
        tests++; if ({out_valid, busy, done} !== 3'b000) begin fails++; $display("FAIL abort_idle got %b want 000", {out_valid, busy, done}); end
        exp_q.delete();
        for (int k = 0; k < 8; k++) begin
            if (done || busy || out_valid) dcnt++;
            step();
            @(negedge clk);
        end
        tests++; if (dcnt != 0) begin fails++; $display("FAIL abort_quiet got %0d active cycles want 0", dcnt); end
        step();

        mode = 1'b0; sel = 4'd2; sel_valid = 1'b1; out_ready = 1'b0;
        push_exp(2);
        step();
        sel_valid = 1'b0; mode = 1'b1; dwell = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        @(negedge clk);
        tests++; if ({busy, out_valid, out_ch, out_data} !== {1'b0, 1'b1, 4'd2, 8'h12}) begin
            fails++; $display("FAIL start_held got %b/%b/%0d/%h want 0/1/2/12", busy, out_valid, out_ch, out_data);
        end
        step();
        out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (!out_valid || exp_q.size() == 0) begin fails++; $display("FAIL held_xfer got valid %0b q %0d want 1 1", out_valid, exp_q.size()); end
        else begin
            exp_e = exp_q.pop_front();
            if ({out_ch, out_data} !== exp_e) begin fails++; $display("FAIL held_data got %h want %h", {out_ch, out_data}, exp_e); end
        end
        step();
        @(negedge clk);
        tests++; if ({out_valid, busy} !== 2'b00) begin fails++; $display("FAIL held_drop got %b want 00", {out_valid, busy}); end
        step();
    endtask

    task automatic test_reset_midscan();
        int dcnt;
        logic found;
        dcnt = 0; found = 1'b0;
        mode = 1'b1; dwell = 8'd0; out_ready = 1'b1; start = 1'b1;
        for (int c = 0; c < N; c++) push_exp(c);
        step();
        start = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (out_valid && out_ch == 4'd9) found = 1'b1;
            else begin
                if (out_valid) void'(exp_q.pop_front());
                step();
            end
        end
        rst_n = 1'b0;
        #1;
        tests++; if (!found) begin fails++; $display("FAIL rst_reach got not found want channel 9"); end
        tests++; if ({out_data, out_ch} !== 12'h000) begin fails++; $display("FAIL rst_mid_data got %h want 000", {out_data, out_ch}); end
        tests++; if ({out_valid, busy, done} !== 3'b000) begin fails++; $display("FAIL rst_mid_ctrl got %b want 000", {out_valid, busy, done}); end
        exp_q.delete();
        @(posedge clk);
        #2;
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL rst_mid_done got %0b want 0", done); end
        rst_n = 1'b1;
        step();
        for (int c = 0; c < N; c++) push_exp(c);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 40 && dcnt == 0; k++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                tests++;
                if (exp_q.size() == 0) begin fails++; $display("FAIL rescan_underflow got empty want entry"); end
                else begin
                    exp_e = exp_q.pop_front();
                    if ({out_ch, out_data} !== exp_e) begin fails++; $display("FAIL rescan_data got %h want %h", {out_ch, out_data}, exp_e); end
                end
            end
            if (done) dcnt++;
            step();
        end
        tests++; if (dcnt != 1 || exp_q.size() != 0) begin fails++; $display("FAIL rescan_done got %0d done %0d left want 1 0", dcnt, exp_q.size()); end
        step();
    endtask

    task automatic test_n12();
        sel12 = 4'd13; sel_valid12 = 1'b1;
        step();
        sel_valid12 = 1'b0;
        @(negedge clk);
        tests++; if ({out_valid12, out_ch12, out_data12} !== {1'b1, 4'd13, 8'h00}) begin
            fails++; $display("FAIL n12_oor got %b/%0d/%h want 1/13/00", out_valid12, out_ch12, out_data12);
        end
        step();
        sel12 = 4'd11; sel_valid12 = 1'b1;
        step();
        sel_valid12 = 1'b0;
        @(negedge clk);
        tests++; if ({out_valid12, out_ch12, out_data12} !== {1'b1, 4'd11, 8'h1b}) begin
            fails++; $display("FAIL n12_last got %b/%0d/%h want 1/11/1b", out_valid12, out_ch12, out_data12);
        end
        tests++; if ({busy12, done12} !== 2'b00) begin fails++; $display("FAIL n12_ctrl got %b want 00", {busy12, done12}); end
        step();
    endtask

    initial begin
        for (int c = 0; c < N; c++) in_data[c*W +: W] = 8'(c + 'h10);
        for (int c = 0; c < 12; c++) in_data12[c*W +: W] = 8'(c + 'h10);
        test_reset();
        test_direct();
        test_back_to_back();
        test_scan_dwell0();
        test_scan_dwell3();
        test_abort();
        test_reset_midscan();
        test_n12();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
